// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared state encoding and defaults for the motor direction sequencer
package motor_pkg;

  typedef enum logic [1:0] {
    ST_BRAKED = 2'd0,
    ST_DEAD   = 2'd1,
    ST_RUN    = 2'd2
  } state_e;

  localparam int DEAD_CYCLES_DEFAULT = 1000;
  localparam int CNT_W_DEFAULT       = 16;

endpackage

// File: rtl/dead_time_counter.sv
// rtl/dead_time_counter.sv - loadable down-counter that saturates at zero
module dead_time_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic             zero,
  output logic             first
);

  logic [CNT_W-1:0] count_q, count_d;
  logic             first_q, first_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (en && (count_q != '0)) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  // A zero load is a clear, not the start of a dead-time window.
  assign first_d = load && (load_val != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      first_q <= 1'b0;
    end else begin
      count_q <= count_d;
      first_q <= first_d;
    end
  end

  assign zero  = (count_q == '0);
  assign first = first_q;

endmodule

// File: rtl/motor_dir_sequencer.sv
// rtl/motor_dir_sequencer.sv - command-driven direction/brake sequencer with braked dead-time
module motor_dir_sequencer
  import motor_pkg::*;
#(
  parameter int DEAD_CYCLES = DEAD_CYCLES_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic cmd_valid,
  output logic cmd_ready,
  input  logic cmd_dir,
  input  logic cmd_brake,
  input  logic fault,
  output logic direction,
  output logic brake,
  output logic pwm_gate,
  output logic busy
);

  localparam logic [CNT_W-1:0] DEAD_LOAD = CNT_W'(DEAD_CYCLES - 1);

  state_e state_q, state_d;
  logic   direction_q, direction_d;
  logic   brake_q, brake_d;
  logic   pwm_gate_q, pwm_gate_d;
  logic   pending_dir_q, pending_dir_d;

  logic             cnt_load;
  logic [CNT_W-1:0] cnt_load_val;
  logic             cnt_en;
  logic             cnt_zero;
  logic             cnt_first;
  logic             accept;

  dead_time_counter #(
    .CNT_W (CNT_W)
  ) u_dead_cnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .zero     (cnt_zero),
    .first    (cnt_first)
  );

  assign cmd_ready = (state_q != ST_DEAD) && !fault && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == ST_DEAD);

  always_comb begin
    state_d       = state_q;
    direction_d   = direction_q;
    brake_d       = brake_q;
    pwm_gate_d    = pwm_gate_q;
    pending_dir_d = pending_dir_q;
    cnt_load      = 1'b0;
    cnt_load_val  = '0;
    cnt_en        = 1'b0;

    if (fault) begin
      state_d    = ST_BRAKED;
      brake_d    = 1'b1;
      pwm_gate_d = 1'b0;
      cnt_load   = 1'b1;
    end else begin
      case (state_q)
        ST_BRAKED: begin
          brake_d    = 1'b1;
          pwm_gate_d = 1'b0;
          if (accept && !cmd_brake) begin
            pending_dir_d = cmd_dir;
            cnt_load      = 1'b1;
            cnt_load_val  = DEAD_LOAD;
            state_d       = ST_DEAD;
          end
        end
        ST_DEAD: begin
          cnt_en = 1'b1;
          // Direction moves one edge after brake rose, never alongside it.
          if (cnt_first) begin
            direction_d = pending_dir_q;
          end
          if (cnt_zero) begin
            state_d    = ST_RUN;
            brake_d    = 1'b0;
            pwm_gate_d = 1'b1;
          end
        end
        ST_RUN: begin
          if (accept) begin
            if (cmd_brake) begin
              state_d    = ST_BRAKED;
              brake_d    = 1'b1;
              pwm_gate_d = 1'b0;
            end else if (cmd_dir != direction_q) begin
              pending_dir_d = cmd_dir;
              cnt_load      = 1'b1;
              cnt_load_val  = DEAD_LOAD;
              state_d       = ST_DEAD;
              brake_d       = 1'b1;
              pwm_gate_d    = 1'b0;
            end
          end
        end
        default: begin
          state_d    = ST_BRAKED;
          brake_d    = 1'b1;
          pwm_gate_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_BRAKED;
      direction_q   <= 1'b0;
      brake_q       <= 1'b1;
      pwm_gate_q    <= 1'b0;
      pending_dir_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      direction_q   <= direction_d;
      brake_q       <= brake_d;
      pwm_gate_q    <= pwm_gate_d;
      pending_dir_q <= pending_dir_d;
    end
  end

  assign direction = direction_q;
  assign brake     = brake_q;
  assign pwm_gate  = pwm_gate_q;

endmodule

// File: tb/tb_motor_dir_sequencer.sv
// tb/tb_motor_dir_sequencer.sv - scoreboard bench for motor_dir_sequencer with a 4-cycle dead time
module tb_motor_dir_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic cmd_dir = 1'b0;
  logic cmd_brake = 1'b0;
  logic fault = 1'b0;
  logic direction;
  logic brake;
  logic pwm_gate;
  logic busy;

  typedef struct {
    string tag;
    logic  brake;
    logic  dir;
    logic  pwm;
    logic  busy;
    logic  rdy;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic have_prev = 1'b0;
  logic prev_brake;
  logic prev_dir;

  motor_dir_sequencer #(
    .DEAD_CYCLES (4),
    .CNT_W       (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_dir   (cmd_dir),
    .cmd_brake (cmd_brake),
    .fault     (fault),
    .direction (direction),
    .brake     (brake),
    .pwm_gate  (pwm_gate),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One clock cycle: drive this cycle's inputs, queue the outputs expected during it.
  task automatic cyc(input string tag, input logic r, input logic v, input logic d,
                     input logic b, input logic f, input logic eb, input logic edir,
                     input logic epwm, input logic ebusy, input logic erdy);
    exp_t e;
    @(posedge clk);
    #1;
    reset     = r;
    cmd_valid = v;
    cmd_dir   = d;
    cmd_brake = b;
    fault     = f;
    e.tag = tag; e.brake = eb; e.dir = edir; e.pwm = epwm; e.busy = ebusy; e.rdy = erdy;
    sb_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      cur = sb_q.pop_front();
      check_eq({cur.tag, ".brake"},     brake,     cur.brake);
      check_eq({cur.tag, ".direction"}, direction, cur.dir);
      check_eq({cur.tag, ".pwm_gate"},  pwm_gate,  cur.pwm);
      check_eq({cur.tag, ".busy"},      busy,      cur.busy);
      check_eq({cur.tag, ".cmd_ready"}, cmd_ready, cur.rdy);
    end
    if (!reset && have_prev && !prev_brake && !brake) begin
      check_eq("dir_hold_while_driving", direction, prev_dir);
    end
    have_prev  = !reset;
    prev_brake = brake;
    prev_dir   = direction;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: sequence did not complete, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //    tag            r  v  d  b  f   brk dir pwm bsy rdy
    cyc("reset0",        1, 0, 0, 0, 0,  1,  0,  0,  0,  0);
    cyc("reset1",        1, 0, 0, 0, 0,  1,  0,  0,  0,  0);
    cyc("idle",          0, 0, 0, 0, 0,  1,  0,  0,  0,  1);

    cyc("fwd_acc",       0, 1, 1, 0, 0,  1,  0,  0,  0,  1);
    cyc("fwd_dead1",     0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("fwd_dead2",     0, 0, 0, 0, 0,  1,  1,  0,  1,  0);
    cyc("fwd_dead3",     0, 0, 0, 0, 0,  1,  1,  0,  1,  0);
    cyc("fwd_dead4",     0, 0, 0, 0, 0,  1,  1,  0,  1,  0);
    cyc("fwd_run_same",  0, 1, 1, 0, 0,  0,  1,  1,  0,  1);
    cyc("fwd_run_hold",  0, 0, 0, 0, 0,  0,  1,  1,  0,  1);

    cyc("rev_acc",       0, 1, 0, 0, 0,  0,  1,  1,  0,  1);
    cyc("rev_dead1",     0, 1, 0, 0, 0,  1,  1,  0,  1,  0);
    cyc("rev_dead2",     0, 1, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("rev_dead3",     0, 1, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("rev_dead4",     0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("rev_run",       0, 0, 0, 0, 0,  0,  0,  1,  0,  1);

    cyc("brk_acc",       0, 1, 0, 1, 0,  0,  0,  1,  0,  1);
    cyc("brk_repeat",    0, 1, 1, 1, 0,  1,  0,  0,  0,  1);
    cyc("brk_hold",      0, 0, 0, 0, 0,  1,  0,  0,  0,  1);

    cyc("flt_acc",       0, 1, 1, 0, 0,  1,  0,  0,  0,  1);
    cyc("flt_dead1",     0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("flt_dead2",     0, 1, 0, 0, 1,  1,  1,  0,  1,  0);
    cyc("flt_braked",    0, 0, 0, 0, 0,  1,  1,  0,  0,  1);
    for (int i = 0; i < 3; i++) begin
      cyc("flt_no_resume", 0, 0, 0, 0, 0, 1, 1,  0,  0,  1);
    end

    cyc("refw_acc",      0, 1, 0, 0, 0,  1,  1,  0,  0,  1);
    cyc("refw_dead1",    0, 0, 0, 0, 0,  1,  1,  0,  1,  0);
    cyc("refw_dead2",    0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("refw_dead3",    0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("refw_dead4",    0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("refw_run",      0, 0, 0, 0, 0,  0,  0,  1,  0,  1);

    cyc("frun_fault",    0, 1, 1, 0, 1,  0,  0,  1,  0,  0);
    cyc("frun_held",     0, 1, 1, 0, 1,  1,  0,  0,  0,  0);
    cyc("frun_release",  0, 0, 0, 0, 0,  1,  0,  0,  0,  1);
    cyc("frun_idle",     0, 0, 0, 0, 0,  1,  0,  0,  0,  1);

    cyc("rdead_acc",     0, 1, 1, 0, 0,  1,  0,  0,  0,  1);
    cyc("rdead_dead1",   0, 0, 0, 0, 0,  1,  0,  0,  1,  0);
    cyc("rdead_reset",   1, 0, 0, 0, 0,  1,  1,  0,  1,  0);
    cyc("rdead_after",   0, 0, 0, 0, 0,  1,  0,  0,  0,  1);
    cyc("rdead_idle",    0, 0, 0, 0, 0,  1,  0,  0,  0,  1);

    @(negedge clk);
    #1;
    check_eq("scoreboard_drained", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
